// File: rtl/sdio_crc7.sv
// rtl/sdio_crc7.sv - bit-serial CRC-7 (x^7 + x^3 + 1) generator/checker for SD/SDIO command tokens.
// Optional SDIO_CRC7_BYTE_EN adds an 8-bit-per-cycle fold path (i_byte_en / i_byte_in).
module sdio_crc7 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  input  logic       i_shift,
`ifdef SDIO_CRC7_BYTE_EN
  input  logic       i_byte_en,
  input  logic [7:0] i_byte_in,
`endif
  output logic [6:0] o_crc,
  output logic       o_out_bit,
  output logic       o_crc_zero
);

  localparam logic [6:0] POLY = 7'h09;

  logic [6:0] r_crc;
  logic [6:0] w_next;

  function automatic logic [6:0] f_step(input logic [6:0] crc_in, input logic din);
    logic fb;
    fb     = din ^ crc_in[6];
    f_step = {crc_in[5:0], 1'b0} ^ (fb ? POLY : 7'h00);
  endfunction

`ifdef SDIO_CRC7_BYTE_EN
  // Eight chained serial steps, MSB first, so the byte path matches serial feeding exactly.
  function automatic logic [6:0] f_byte(input logic [6:0] crc_in, input logic [7:0] din);
    logic [6:0] acc;
    acc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      acc = f_step(acc, din[i]);
    end
    f_byte = acc;
  endfunction
`endif

  always_comb begin
    w_next = r_crc;
    if (i_clr) begin
      w_next = 7'h00;
    end else if (i_shift) begin
      w_next = {r_crc[5:0], 1'b0};
`ifdef SDIO_CRC7_BYTE_EN
    end else if (i_byte_en) begin
      w_next = f_byte(r_crc, i_byte_in);
`endif
    end else if (i_en) begin
      w_next = f_step(r_crc, i_bit);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= 7'h00;
    end else begin
      r_crc <= w_next;
    end
  end

  assign o_crc      = r_crc;
  assign o_out_bit  = r_crc[6];
  assign o_crc_zero = (r_crc == 7'h00);

endmodule

// File: tb/tb_sdio_crc7.sv
// tb/tb_sdio_crc7.sv - self-checking bench for sdio_crc7; reference CRC is polynomial long division.
// Define SDIO_CRC7_BYTE_EN to also exercise the byte fold path.
module tb_sdio_crc7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, en, din, shift;
  logic [6:0] crc;
  logic       out_bit, crc_zero;
`ifdef SDIO_CRC7_BYTE_EN
  logic       byte_en;
  logic [7:0] byte_in;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdio_crc7 dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_en       (en),
    .i_bit      (din),
    .i_shift    (shift),
`ifdef SDIO_CRC7_BYTE_EN
    .i_byte_en  (byte_en),
    .i_byte_in  (byte_in),
`endif
    .o_crc      (crc),
    .o_out_bit  (out_bit),
    .o_crc_zero (crc_zero)
  );

  // Remainder of (old * x^n + data * x^7) mod (x^7 + x^3 + 1), by long division.
  function automatic logic [6:0] crc_ref(input logic [6:0] old, input logic [63:0] data, input int n);
    logic [70:0] d;
    logic [63:0] m;
    m = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    d = ({64'd0, old} << n) ^ ({7'd0, data & m} << 7);
    for (int i = 70; i >= 7; i--) begin
      if (d[i]) d = d ^ (71'h89 << (i - 7));
    end
    return d[6:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [63:0] data, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) tick();
      end
      en = 1'b1; din = data[i];
      tick();
      en = 1'b0; din = 1'b0;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    logic [6:0]  exp_crc;
    logic [6:0]  cmd8_seq;
    logic [39:0] tok;
    int          k;

    rst_n = 1'b0; clr = 1'b0; en = 1'b0; din = 1'b0; shift = 1'b0;
`ifdef SDIO_CRC7_BYTE_EN
    byte_en = 1'b0; byte_in = 8'h00;
`endif
    tick(); tick();
    check("reset_crc", crc, 7'h00);
    check("reset_zero", crc_zero, 1'b1);
    check("reset_out_bit", out_bit, 1'b0);
    rst_n = 1'b1;
    tick();
    check("release_hold", crc, 7'h00);

    // CMD0 and its trailing CRC
    do_clr();
    feed(64'h40_0000_0000, 40, 1'b0);
    check("cmd0_crc", crc, 7'h4A);
    check("cmd0_model", crc, crc_ref(7'h00, 64'h40_0000_0000, 40));
    feed(64'h4A, 7, 1'b0);
    check("cmd0_resid", crc, 7'h00);
    check("cmd0_zero", crc_zero, 1'b1);

    do_clr();
    feed(64'h48_0000_01AA, 40, 1'b1);
    check("cmd8_crc", crc, 7'h43);
    cmd8_seq = 7'b1000011;
    shift = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      check("cmd8_shift_bit", out_bit, cmd8_seq[i]);
      tick();
    end
    shift = 1'b0;
    check("cmd8_after_shift", crc, 7'h00);

    do_clr();
    feed(64'h51_0000_0000, 40, 1'b0);
    check("cmd17_crc", crc, 7'h2A);
    do_clr();
    feed(64'h77_0000_0000, 40, 1'b1);
    check("cmd55_crc", crc, 7'h32);

    // Async reset mid-token: clears between edges, ignores en while low
    do_clr();
    feed(64'h48_00, 16, 1'b0);
    exp_crc = crc_ref(7'h00, 64'h4800, 16);
    check("mid_token_crc", crc, exp_crc);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_crc", crc, 7'h00);
    check("async_rst_zero", crc_zero, 1'b1);
    en = 1'b1; din = 1'b1;
    tick();
    check("rst_ignores_en", crc, 7'h00);
    en = 1'b0; din = 1'b0; rst_n = 1'b1;
    tick();
    check("rst_release_no_acc", crc, 7'h00);

    // Priority
    feed(64'h1, 1, 1'b0);
    check("single_one", crc, 7'h09);
    for (int i = 0; i < 5; i++) tick();
    check("hold_5", crc, 7'h09);
    shift = 1'b1; en = 1'b1; din = 1'b1;
    tick();
    shift = 1'b0; en = 1'b0; din = 1'b0;
    check("shift_over_en", crc, 7'h12);
    clr = 1'b1; en = 1'b1; din = 1'b1;
    tick();
    clr = 1'b0; en = 1'b0; din = 1'b0;
    check("clr_over_en", crc, 7'h00);
    clr = 1'b1; shift = 1'b1;
    feed(64'h1, 1, 1'b0);
    clr = 1'b0; shift = 1'b0;
    tick();
    check("clr_over_shift", crc, 7'h00);

    // Random tokens, partial shift-out, continued accumulation
    for (int t = 0; t < 24; t++) begin
      tok = {2'b01, 6'($urandom), 32'($urandom)};
      do_clr();
      feed({24'd0, tok}, 40, 1'b1);
      exp_crc = crc_ref(7'h00, {24'd0, tok}, 40);
      check("rand_token", crc, exp_crc);
      k = $urandom_range(0, 7);
      shift = 1'b1;
      for (int i = 0; i < k; i++) begin
        check("rand_shift_bit", out_bit, exp_crc[6]);
        exp_crc = {exp_crc[5:0], 1'b0};
        tick();
      end
      shift = 1'b0;
      check("rand_after_shift", crc, exp_crc);
      begin
        logic [7:0] extra;
        extra = 8'($urandom);
        feed({56'd0, extra}, 8, 1'b1);
        exp_crc = crc_ref(exp_crc, {56'd0, extra}, 8);
        check("rand_extra", crc, exp_crc);
        check("rand_zero_flag", crc_zero, exp_crc == 7'h00);
      end
    end

`ifdef SDIO_CRC7_BYTE_EN
    do_clr();
    byte_en = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      byte_in = (i == 4) ? 8'h40 : 8'h00;
      tick();
    end
    byte_en = 1'b0;
    check("byte_cmd0", crc, 7'h4A);

    do_clr();
    byte_en = 1'b1; byte_in = 8'h48; tick();
    byte_in = 8'h00; tick();
    byte_en = 1'b0;
    feed(64'h00, 8, 1'b1);
    byte_en = 1'b1; byte_in = 8'h01; tick();
    byte_en = 1'b0;
    feed(64'hAA, 8, 1'b0);
    check("byte_mixed_cmd8", crc, 7'h43);

    for (int t = 0; t < 8; t++) begin
      logic [7:0] b;
      exp_crc = crc;
      b = 8'($urandom);
      byte_en = 1'b1; byte_in = b; en = 1'b1; din = 1'b1;
      tick();
      byte_en = 1'b0; en = 1'b0; din = 1'b0;
      check("byte_over_en", crc, crc_ref(exp_crc, {56'd0, b}, 8));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdio_crc7.md
Name: sdio_crc7

Overview:
- Bit-serial CRC-7 generator/checker for SD/SDIO command and response tokens (polynomial x^7 + x^3 + 1, initial value 0, no final XOR).
- Sits beside the SDIO device PHY command-line state machine, clocked by the SDIO clock.
- Accumulates the CMD/response bit stream MSB first, exposes the 7-bit remainder, and can shift the remainder out serially for transmission.

Parameters:
- None. Width (7) and polynomial (0x09) are fixed.

Ports:
- clk  input  1  SDIO clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; crc cleared to 0 while low.
- clr  input  1  synchronous clear, active high; restarts accumulation for a new token.
- en  input  1  accumulate enable; bit is folded into the CRC this cycle.
- bit  input  1  serial data bit, MSB of token first.
- shift  input  1  shift-out mode: register shifts left one place, zero fill, no feedback.
- crc  output  7  current CRC register value.
- out_bit  output  1  crc[6]; next CRC bit to drive during shift-out.
- crc_zero  output  1  high when crc == 0. Checking a received token including its 7 CRC bits yields 1 when the token is good.

Behaviour:
- Register crc[6:0]. Reset value is 0; out_bit = 0 and crc_zero = 1 during and after reset.
- Accumulate step when en = 1: fb = bit ^ crc[6]; next crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00). Equivalently crc[0] <= fb and crc[3] <= crc[2] ^ fb; other bits shift.
- Shift step when shift = 1: crc <= {crc[5:0], 1'b0}.
- Priority per clock edge: rst low (async) > clr > shift > en. Lower-priority requests in the same cycle are discarded, e.g. clr with en gives crc = 0 and the bit is lost.
- With no request asserted, crc holds.
- One-cycle latency: crc reflects bits sampled up to and including the previous edge. out_bit and crc_zero are combinational from the crc register.
- A 40-bit token (start, dir, 6-bit index, 32-bit arg) fed over 40 en cycles leaves the token CRC in crc.
- Shift-out: assert shift for 7 cycles. out_bit presents crc[6] before the first shift, then the following bits in turn. crc is 0 after the 7th shift.
- Reset asserted mid-token clears crc immediately without waiting for a clock edge. Release of reset is taken synchronously at the next edge; no accumulation occurs on the release edge unless en is high.
- No X propagation: bit/en are ignored while rst is low.

Optional Feature:
- Macro SDIO_CRC7_BYTE_EN.
- When defined, adds ports byte_en (input, 1) and byte_in (input, 8).
- With byte_en = 1, the 8 bits of byte_in are folded in within one cycle, MSB first. The result is identical to 8 consecutive serial accumulate steps.
- Priority: clr > shift > byte_en > en. With both byte_en and en high, only the byte is processed.
- When not defined, the ports and logic are absent and behaviour is serial only.

Test Plan:
- Reset: drive rst low asynchronously between edges with crc nonzero -> crc = 0 immediately, crc_zero = 1.
- CMD0: clr, then serially feed 0x40 00 00 00 00 (40 bits) -> crc = 7'h4A. Continue feeding the 7 CRC bits 1001010 -> crc = 0, crc_zero = 1.
- CMD8 and CMD17/CMD55:
  - 0x48 00 00 01 AA -> crc = 7'h43.
  - 0x51 00 00 00 00 -> 7'h2A.
  - 0x77 00 00 00 00 -> 7'h32.
- Shift-out: after the CMD8 token, assert shift 7 cycles -> out_bit sequence 1,0,0,0,0,1,1; crc = 0 afterwards.
- Priority: clr and en with bit = 1 in the same cycle -> crc = 0. en held low for 5 cycles -> crc unchanged. Single bit 1 from 0 -> crc = 7'h09.
- With SDIO_CRC7_BYTE_EN: five byte_en cycles of 0x40,0,0,0,0 -> crc = 7'h4A. Mixed byte and serial feeding of CMD8 -> 7'h43.
